// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, RISC-V load/store funct3 codes,
// and the illegal-funct3 check.
package dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_WAIT   = 2'd1,
    DM_ACCESS = 2'd2,
    DM_RESP   = 2'd3
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have signed-size encodings; loads add the two unsigned forms.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for loads/stores: byte enables, replicated write word, load extension.
// With DMEM_MISALIGN_ERR_EN defined, misaligned half/word accesses raise o_misalign.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic        o_misalign,
  output logic [31:0] o_ldata
);

`ifdef DMEM_MISALIGN_ERR_EN
  localparam logic MisEn = 1'b1;
`else
  localparam logic MisEn = 1'b0;
`endif

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_raw[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_be       = 4'b0000;
    o_wword    = i_wdata;
    o_misalign = 1'b0;
    o_ldata    = i_raw;
    case (i_f3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: o_ldata = {24'h0, w_byte};
      F3_H: begin
        o_be       = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wword    = {2{i_wdata[15:0]}};
        o_misalign = MisEn & i_addr_lo[0];
        o_ldata    = {{16{w_half[15]}}, w_half};
      end
      F3_HU: begin
        o_misalign = MisEn & i_addr_lo[0];
        o_ldata    = {16'h0, w_half};
      end
      F3_W: begin
        o_be       = 4'b1111;
        o_misalign = MisEn & (|i_addr_lo);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, word RAM.
// Misalignment errors are enabled by defining DMEM_MISALIGN_ERR_EN (handled in dmem_lane_ctrl).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e r_state, w_next;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_addr;
  logic          r_we;
  logic [2:0]    r_f3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_raw;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic          w_misalign;
  logic [31:0]   w_ldata;
  logic          w_err;
  logic          w_unused;

  // Address bits above the RAM index alias onto the same words.
  assign w_unused = ^req_addr[31:AW+2];

  assign req_ready = (r_state == DM_IDLE);
  assign rsp_valid = (r_state == DM_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept  = req_ready & req_valid;
  assign w_idx     = r_addr[AW+1:2];
  assign w_raw     = r_mem[w_idx];
  assign w_err     = f3_illegal(r_we, r_f3) | w_misalign;

  dmem_lane_ctrl u_lane (
    .i_f3       (r_f3),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_raw      (w_raw),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_misalign (w_misalign),
    .o_ldata    (w_ldata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      DM_IDLE:   if (req_valid) w_next = (WAIT_STATES == 0) ? DM_ACCESS : DM_WAIT;
      DM_WAIT:   if (r_cnt == 4'd1) w_next = DM_ACCESS;
      DM_ACCESS: w_next = DM_RESP;
      DM_RESP:   if (rsp_ready) w_next = DM_IDLE;
      default:   w_next = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= DM_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_cnt <= 4'(WAIT_STATES);
      else if (r_state == DM_WAIT) r_cnt <= r_cnt - 4'd1;
      if (r_state == DM_ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (r_we || w_err) ? 32'h0 : w_ldata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr[AW+1:0];
      r_we    <= req_we;
      r_f3    <= req_f3;
      r_wdata <= req_wdata;
    end
  end

  // Write only from ACCESS with reset released, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (rst && r_state == DM_ACCESS && r_we && !w_err) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
    end
  end

endmodule
